fitof_pipe: RTL and testbench

//  Pipelined 32-bit integer -> IEEE-754 binary32 converter (fcvt.s.w), the reverse data direction of the
//  FPU compare path (float in, integer 0/1 out). Sits in the FPU pipeline next to the other float ops.
//  Two register stages, valid/ready handshake on both sides; accepts one conversion per cycle when unstalled.

---
 rtl/fitof_pipe.sv | 102 ++++++++++
 tb/tb_fitof_pipe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fitof_pipe.sv
// Two-stage pipelined int32 -> binary32 converter (fcvt.s.w / fcvt.s.wu), RNE rounding.
// Optional inexact flag output is enabled by defining FITOF_INEXACT_EN.
module fitof_pipe #(
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] x_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
`ifdef FITOF_INEXACT_EN
  output logic        inexact_o,
`endif
  output logic [31:0] y_o
);

  logic adv1, adv2;

  logic        s1_valid_q;
  logic        s1_sign_q, s1_sign_d;
  logic [31:0] s1_mag_q, s1_mag_d;
  logic [5:0]  s1_lz_q, s1_lz_d;
  logic        s1_zero_q, s1_zero_d;

  logic        s2_valid_q;
  logic [31:0] y_q, y_d;

  logic [30:0] norm;
  logic [22:0] frac, frac_r;
  logic        guard, sticky, round_up, carry;
  logic [7:0]  exp_b;

  assign adv2       = !s2_valid_q || out_ready_i;
  assign adv1       = !s1_valid_q || adv2;
  assign in_ready_o = adv1;

  // Stage 1: sign/magnitude split and leading-zero count. -2^31 maps to 2^31 exactly.
  always_comb begin
    s1_sign_d = SIGNED_IN && x_i[31];
    s1_mag_d  = s1_sign_d ? (~x_i + 32'd1) : x_i;
    s1_zero_d = (s1_mag_d == 32'd0);
    s1_lz_d   = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (s1_mag_d[i]) s1_lz_d = 6'(31 - i);
    end
  end

  // Stage 2: normalise so the leading one drops off the top, then round to nearest even.
  always_comb begin
    norm            = 31'(s1_mag_q << s1_lz_q);
    frac            = norm[30:8];
    guard           = norm[7];
    sticky          = |norm[6:0];
    round_up        = guard && (sticky || frac[0]);
    {carry, frac_r} = {1'b0, frac} + {23'd0, round_up};
    exp_b           = 8'd158 - {2'b00, s1_lz_q} + {7'd0, carry};
    y_d             = {s1_sign_q, exp_b, carry ? 23'd0 : frac_r};
    if (s1_zero_q) y_d = 32'h0000_0000;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      y_q        <= 32'h0;
    end else begin
      if (adv1) s1_valid_q <= in_valid_i;
      if (adv2) s2_valid_q <= s1_valid_q;
      if (adv2 && s1_valid_q) y_q <= y_d;
    end
  end

  // Operand registers need no reset: they are qualified by s1_valid_q.
  always_ff @(posedge clk_i) begin
    if (in_valid_i && adv1) begin
      s1_sign_q <= s1_sign_d;
      s1_mag_q  <= s1_mag_d;
      s1_lz_q   <= s1_lz_d;
      s1_zero_q <= s1_zero_d;
    end
  end

`ifdef FITOF_INEXACT_EN
  logic inexact_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inexact_q <= 1'b0;
    end else if (adv2 && s1_valid_q) begin
      inexact_q <= !s1_zero_q && (guard || sticky);
    end
  end

  assign inexact_o = inexact_q;
`endif

  assign out_valid_o = s2_valid_q;
  assign y_o         = y_q;

endmodule

// File: tb/tb_fitof_pipe.sv
// Bench for fitof_pipe: signed and unsigned instances share stimulus; a reference
// float-rounding model feeds per-instance scoreboards, plus literal directed checks.
module tb_fitof_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] x;
  logic        in_ready_s, in_ready_u, ov_s, ov_u;
  logic [31:0] y_s, y_u;
`ifdef FITOF_INEXACT_EN
  logic        ix_s, ix_u;
`endif

  int nchk  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  fitof_pipe #(.SIGNED_IN(1'b1)) u_dut_s (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_s), .x_i(x),
    .out_valid_o(ov_s), .out_ready_i(out_ready),
`ifdef FITOF_INEXACT_EN
    .inexact_o(ix_s),
`endif
    .y_o(y_s)
  );

  fitof_pipe #(.SIGNED_IN(1'b0)) u_dut_u (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_u), .x_i(x),
    .out_valid_o(ov_u), .out_ready_i(out_ready),
`ifdef FITOF_INEXACT_EN
    .inexact_o(ix_u),
`endif
    .y_o(y_u)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact magnitude, find exponent, round the shifted-out remainder to nearest even.
  function automatic logic [32:0] model(input logic [31:0] xv, input bit sgn);
    longint unsigned m, q, r, half;
    int e, sh;
    bit s;
    logic [7:0] e8;
    s = sgn && xv[31];
    m = s ? (64'h1_0000_0000 - {32'h0, xv}) : {32'h0, xv};
    if (m == 0) return 33'h0;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    r = 0;
    if (e <= 23) begin
      q = m << (23 - e);
    end else begin
      sh   = e - 23;
      q    = m >> sh;
      r    = m - (q << sh);
      half = 64'd1 << (sh - 1);
      if (r > half || (r == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin
        q = 64'd1 << 23;
        e++;
      end
    end
    e8 = 8'(e + 127);
    return {r != 0, s, e8, q[22:0]};
  endfunction

  logic [32:0] q_s[$];
  logic [32:0] q_u[$];
  logic        stall_s = 1'b0, stall_u = 1'b0;
  logic [31:0] prev_s, prev_u;
  logic [32:0] e;

  // Compare process: outputs are checked on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      q_s.delete();
      q_u.delete();
      stall_s = 1'b0;
      stall_u = 1'b0;
    end else begin
      if (ov_s && stall_s) check("stall_stable_s", y_s, prev_s);
      if (ov_s && out_ready) begin
        if (q_s.size() == 0) check("unexpected_out_s", 32'd1, 32'd0);
        else begin
          e = q_s.pop_front();
          check("sb_y_s", y_s, e[31:0]);
`ifdef FITOF_INEXACT_EN
          check("sb_inexact_s", {31'd0, ix_s}, {31'd0, e[32]});
`endif
        end
      end
      if (ov_u && stall_u) check("stall_stable_u", y_u, prev_u);
      if (ov_u && out_ready) begin
        if (q_u.size() == 0) check("unexpected_out_u", 32'd1, 32'd0);
        else begin
          e = q_u.pop_front();
          check("sb_y_u", y_u, e[31:0]);
`ifdef FITOF_INEXACT_EN
          check("sb_inexact_u", {31'd0, ix_u}, {31'd0, e[32]});
`endif
        end
      end
      stall_s = ov_s && !out_ready;
      stall_u = ov_u && !out_ready;
      prev_s  = y_s;
      prev_u  = y_u;
      if (in_valid && in_ready_s) q_s.push_back(model(x, 1'b1));
      if (in_valid && in_ready_u) q_u.push_back(model(x, 1'b0));
    end
  end

  // One isolated request; result must appear exactly two edges after it is presented.
  task automatic single(input logic [31:0] xv, input logic [31:0] ys, input logic [31:0] yu,
                        input bit is, input bit iu);
    out_ready = 1'b1;
    x         = xv;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_early_ov", {31'd0, ov_s}, 32'd0);
    @(posedge clk); #1;
    check("lat_ov_s", {31'd0, ov_s}, 32'd1);
    check("lat_ov_u", {31'd0, ov_u}, 32'd1);
    check("lit_y_s", y_s, ys);
    check("lit_y_u", y_u, yu);
`ifdef FITOF_INEXACT_EN
    check("lit_ix_s", {31'd0, ix_s}, {31'd0, is});
    check("lit_ix_u", {31'd0, ix_u}, {31'd0, iu});
`else
    if (is && iu) x = xv; // flags only observable with the inexact port built in
`endif
  endtask

  logic [31:0] vec[12] = '{32'h0000_0002, 32'h0100_0001, 32'h0100_0003, 32'h7FFF_FFFF,
                           32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_FF9C,
                           32'h00FF_FFFF, 32'h8765_4321, 32'h0000_0000, 32'hFFFF_FFFE};

  initial begin
    int sent, zeros, k;
    bit acc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ov", {31'd0, ov_s}, 32'd0);
    check("rst_y", y_s, 32'h0);
    check("rst_in_ready", {31'd0, in_ready_s}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    single(32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0);
    single(32'hFFFF_FFFF, 32'hBF80_0000, 32'h4F80_0000, 1'b0, 1'b1);
    single(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
    single(32'h8000_0000, 32'hCF00_0000, 32'h4F00_0000, 1'b0, 1'b0);
    single(32'd16777217,  32'h4B80_0000, 32'h4B80_0000, 1'b1, 1'b1);
    single(32'd16777219,  32'h4B80_0002, 32'h4B80_0002, 1'b1, 1'b1);
    single(32'h7FFF_FFFF, 32'h4F00_0000, 32'h4F00_0000, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Burst of 8 with the consumer stalled on cycles 3..5.
    sent = 0; zeros = 0; k = 0;
    while (sent < 8 && k < 40) begin
      out_ready = !(k >= 3 && k <= 5);
      in_valid  = 1'b1;
      x         = vec[sent] ^ 32'(k);
      #1;
      if (!in_ready_s) zeros++;
      acc = in_ready_s;
      @(posedge clk); #1;
      if (acc) sent++;
      k++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("burst_sent", 32'(sent), 32'd8);
    check("burst_in_ready_low_cycles", 32'(zeros), 32'd3);
    repeat (4) @(posedge clk);
    #1;

    // Directed stream with intermittent back-pressure.
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      x        = vec[i];
      k        = 0;
      do begin
        out_ready = (k % 3) != 2;
        #1;
        acc = in_ready_s;
        @(posedge clk); #1;
        k++;
      end while (!acc && k < 20);
      if (!acc) check("stream_accept_timeout", 32'd1, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while ((q_s.size() != 0 || q_u.size() != 0) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_empty", 32'(q_s.size() + q_u.size()), 32'd0);

    // Reset mid-stream with requests still being offered.
    in_valid = 1'b1;
    x        = 32'h0000_0005;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_ov", {31'd0, ov_s}, 32'd0);
    check("midrst_y", y_s, 32'h0);
`ifdef FITOF_INEXACT_EN
    check("midrst_ix", {31'd0, ix_u}, 32'd0);
`endif
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_idle", {30'd0, ov_s, ov_u}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
